status_shift_seq: RTL
=====================

STATUS_SHIFT_SEQ -- requirements
Module: status_shift_seq

Interface
REQ-001 Parameter DEPTH, default 4, number of entries in the status save stack (>=2).
REQ-002 Parameter CW, default 6, width of the shift count.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 op  in  3  status op: 0 NOP, 1 LOAD_ALU, 2 LOAD_BUS, 3 SWAP, 4 PUSH, 5 POP, 6 SET_MSR, 7 CLR_MSR.
REQ-006 alu_flags  in  4  {Z,N,C,OVR} from ALU.
REQ-007 bus_flags  in  4  {Z,N,C,OVR} from status bus.
REQ-008 flag_en  in  4  per-flag MSR write enable, same bit order.
REQ-009 usr, msr  out  4 each  current micro and machine status registers.
REQ-010 cond_sel  in  5  bit4 source (0 uSR, 1 MSR), bits3:0 condition code.
REQ-011 ct  out  1  conditional test result.
REQ-012 ci_sel  in  2  carry-in select; co out 1 carry to ALU.
REQ-013 shift_start  in  1; shift_cnt  in  CW; shift_mode  in  2 (0 zero fill, 1 ones fill, 2 rotate through MC, 3 plain rotate).
REQ-014 shout  in  1  bit leaving the datapath on the current step.
REQ-015 shift_en  out  1; fill  out  1  bit entering the datapath this step.
REQ-016 busy, done  out  1 each; stk_full, stk_empty, stk_err  out  1 each.

Function
REQ-017 LOAD_ALU: uSR <= alu_flags; each MSR bit with flag_en set <= alu_flags bit.
REQ-018 LOAD_BUS: each MSR bit with flag_en set <= bus_flags bit; uSR unchanged.
REQ-019 SWAP: uSR and MSR exchange in one cycle; SET_MSR/CLR_MSR: MSR <= 4'b1111 / 4'b0000, ignoring flag_en.
REQ-020 PUSH: {uSR,MSR} written to stack top, count+1; POP: uSR,MSR <= top entry, count-1; both take effect on the same edge.
REQ-021 PUSH when count==DEPTH or POP when count==0: no state change, stk_err set sticky until reset.
REQ-022 stk_full = (count==DEPTH); stk_empty = (count==0); both combinational from count.
REQ-023 ct combinational from selected register: code 0 (N^V)|Z, 1 inverse, 2 N^V, 3 inverse, 4 Z, 5 ~Z, 6 V, 7 ~V, 8 C|Z, 9 ~C&~Z, A C, B ~C, C ~C|Z, D C&~Z, E N, F ~N.
REQ-024 co combinational: ci_sel 0 -> 0, 1 -> 1, 2 -> uSR.C, 3 -> MSR.C.
REQ-025 Sequencer states IDLE, SHIFT, DONE; busy=1 in SHIFT and DONE.
REQ-026 IDLE + shift_start: latch shift_cnt into remaining, latch shift_mode; go SHIFT if cnt>0, else DONE.
REQ-027 SHIFT: shift_en=1 each cycle, remaining decrements; transition to DONE after the step with remaining==1; n-bit shift gives exactly n shift_en cycles.
REQ-028 DONE: done=1 for exactly one cycle, then IDLE; done first visible in cycle n+1 after the start edge.
REQ-029 fill per latched mode: 0 -> 0, 1 -> 1, 2 -> MSR.C, 3 -> shout.
REQ-030 Mode 2: each SHIFT cycle MSR.C <= shout; this overrides any op/flag_en write to MSR.C in the same cycle; other MSR bits still follow op.
REQ-031 shift_start while busy is ignored; shift_cnt/shift_mode changes while busy have no effect.
REQ-032 Status ops are accepted in every sequencer state; POP in mode 2 restores Z,N,OVR but MSR.C follows REQ-030.
REQ-033 Maximum count 2^CW-1 shall complete without wrap.

Reset
REQ-034 reset asserted: uSR=0, MSR=0, stack count=0, stk_err=0, state IDLE, remaining=0; outputs shift_en=0, done=0, busy=0, stk_empty=1, stk_full=0, ct/co per zeroed registers.
REQ-035 reset mid-shift aborts immediately; no done pulse is generated.

Structure
REQ-036 Package status_pkg holds op codes, shift mode codes, flag bit indices (Z=3,N=2,C=1,OVR=0), condition code constants, sequencer state enum.
REQ-037 Sub-module status_stack: parametrised LIFO of DEPTH x 8 bits with push/pop, count, full/empty.

Verification
REQ-038 LOAD_ALU alu_flags=4'b0110, flag_en=4'b0010 -> uSR=0110, MSR=0010; cond_sel=5'h0A -> ct=1.
REQ-039 PUSH x4 then fifth PUSH with DEPTH=4 -> stk_full=1, stk_err=1, count stays 4; POP x4 restores values LIFO order, stk_empty=1.
REQ-040 shift_start, cnt=3, mode 2, MSR.C=1, shout=0,1,0 -> fill=1,0,1; shift_en 3 cycles; MSR.C=0 after; done pulse cycle 4.
REQ-041 shift_start cnt=0 -> no shift_en, done=1 in cycle 1, busy then 0.
REQ-042 reset asserted in 2nd cycle of a cnt=5 shift -> shift_en=0, busy=0 immediately, no done; MSR=0.
REQ-043 LOAD_BUS with flag_en C=1 during mode-2 shift step -> MSR.C takes shout, other enabled bits take bus_flags.

Source files
------------

// File: rtl/status_pkg.sv
// Shared codes for the status/shift sequencer: op codes, shift modes, flag positions,
// condition codes, sequencer state and the condition evaluator.
package status_pkg;

    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_LOAD_ALU = 3'd1;
    localparam logic [2:0] OP_LOAD_BUS = 3'd2;
    localparam logic [2:0] OP_SWAP     = 3'd3;
    localparam logic [2:0] OP_PUSH     = 3'd4;
    localparam logic [2:0] OP_POP      = 3'd5;
    localparam logic [2:0] OP_SET_MSR  = 3'd6;
    localparam logic [2:0] OP_CLR_MSR  = 3'd7;

    localparam logic [1:0] MODE_ZERO   = 2'd0;
    localparam logic [1:0] MODE_ONES   = 2'd1;
    localparam logic [1:0] MODE_ROT_MC = 2'd2;
    localparam logic [1:0] MODE_ROT    = 2'd3;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] CC_LE    = 4'h0;
    localparam logic [3:0] CC_GT    = 4'h1;
    localparam logic [3:0] CC_LT    = 4'h2;
    localparam logic [3:0] CC_GE    = 4'h3;
    localparam logic [3:0] CC_EQ    = 4'h4;
    localparam logic [3:0] CC_NE    = 4'h5;
    localparam logic [3:0] CC_VS    = 4'h6;
    localparam logic [3:0] CC_VC    = 4'h7;
    localparam logic [3:0] CC_CORZ  = 4'h8;
    localparam logic [3:0] CC_NCNZ  = 4'h9;
    localparam logic [3:0] CC_CS    = 4'hA;
    localparam logic [3:0] CC_CC    = 4'hB;
    localparam logic [3:0] CC_NCORZ = 4'hC;
    localparam logic [3:0] CC_CNZ   = 4'hD;
    localparam logic [3:0] CC_MI    = 4'hE;
    localparam logic [3:0] CC_PL    = 4'hF;

    typedef enum logic [1:0] {SEQ_IDLE, SEQ_SHIFT, SEQ_DONE} seqState_e;

    // Codes come in complementary pairs: bits 3:1 pick the base test, bit 0 inverts it.
    function automatic logic condEval(input logic [3:0] flags, input logic [3:0] code);
        logic base;
        case (code[3:1])
            3'd0:    base = (flags[FLAG_N] ^ flags[FLAG_V]) | flags[FLAG_Z];
            3'd1:    base = flags[FLAG_N] ^ flags[FLAG_V];
            3'd2:    base = flags[FLAG_Z];
            3'd3:    base = flags[FLAG_V];
            3'd4:    base = flags[FLAG_C] | flags[FLAG_Z];
            3'd5:    base = flags[FLAG_C];
            3'd6:    base = ~flags[FLAG_C] | flags[FLAG_Z];
            default: base = flags[FLAG_N];
        endcase
        return base ^ code[0];
    endfunction

endpackage

// File: rtl/status_stack.sv
// LIFO used to save and restore {uSR,MSR} pairs; overflow/underflow requests are ignored.
module status_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [W-1:0]    din,
    output logic [W-1:0]    dout,
    output logic [CNTW-1:0] count,
    output logic            full,
    output logic            empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] topIdx;

    assign full   = (count == CNTW'(DEPTH));
    assign empty  = (count == '0);
    assign topIdx = AW'(count - CNTW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CNTW'(1);
        end else if (pop && !empty) begin
            count <= count - CNTW'(1);
        end
    end

    // Storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[count[AW-1:0]] <= din;
        end
    end

    always_comb begin
        dout = '0;
        if (!empty) begin
            dout = mem[topIdx];
        end
    end

endmodule

// File: rtl/status_shift_seq.sv
// Micro/machine status registers with save stack, condition test, carry select
// and a shift-count sequencer that supplies the fill bit for each step.
module status_shift_seq import status_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int CW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    op,
    input  logic [3:0]    alu_flags,
    input  logic [3:0]    bus_flags,
    input  logic [3:0]    flag_en,
    output logic [3:0]    usr,
    output logic [3:0]    msr,
    input  logic [4:0]    cond_sel,
    output logic          ct,
    input  logic [1:0]    ci_sel,
    output logic          co,
    input  logic          shift_start,
    input  logic [CW-1:0] shift_cnt,
    input  logic [1:0]    shift_mode,
    input  logic          shout,
    output logic          shift_en,
    output logic          fill,
    output logic          busy,
    output logic          done,
    output logic          stk_full,
    output logic          stk_empty,
    output logic          stk_err
);

    localparam int CNTW = $clog2(DEPTH + 1);

    seqState_e       state;
    logic [CW-1:0]   remaining;
    logic [1:0]      modeLatched;
    logic [3:0]      nextUsr;
    logic [3:0]      nextMsr;
    logic            errSet;
    logic            stackPush;
    logic            stackPop;
    logic [7:0]      stackTop;
    logic [CNTW-1:0] stackCount;

    status_stack #(.DEPTH(DEPTH), .W(8), .CNTW(CNTW)) stackInst (
        .clk   (clk),
        .reset (reset),
        .push  (stackPush),
        .pop   (stackPop),
        .din   ({usr, msr}),
        .dout  (stackTop),
        .count (stackCount),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_comb begin
        nextUsr   = usr;
        nextMsr   = msr;
        errSet    = 1'b0;
        stackPush = 1'b0;
        stackPop  = 1'b0;
        case (op)
            OP_LOAD_ALU: begin
                nextUsr = alu_flags;
                nextMsr = (msr & ~flag_en) | (alu_flags & flag_en);
            end
            OP_LOAD_BUS: nextMsr = (msr & ~flag_en) | (bus_flags & flag_en);
            OP_SWAP: begin
                nextUsr = msr;
                nextMsr = usr;
            end
            OP_PUSH: begin
                if (stackCount == CNTW'(DEPTH)) errSet = 1'b1;
                else stackPush = 1'b1;
            end
            OP_POP: begin
                if (stackCount == '0) begin
                    errSet = 1'b1;
                end else begin
                    stackPop = 1'b1;
                    nextUsr  = stackTop[7:4];
                    nextMsr  = stackTop[3:0];
                end
            end
            OP_SET_MSR: nextMsr = 4'b1111;
            OP_CLR_MSR: nextMsr = 4'b0000;
            default: ;
        endcase
        // A rotate-through-carry step always owns MSR.C, whatever the op wrote.
        if (state == SEQ_SHIFT && modeLatched == MODE_ROT_MC) begin
            nextMsr[FLAG_C] = shout;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            usr     <= '0;
            msr     <= '0;
            stk_err <= 1'b0;
        end else begin
            usr <= nextUsr;
            msr <= nextMsr;
            if (errSet) stk_err <= 1'b1;
        end
    end

    // Sequencer: a count of n yields n SHIFT cycles, then one DONE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= SEQ_IDLE;
            remaining   <= '0;
            modeLatched <= MODE_ZERO;
            shift_en    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                SEQ_IDLE: begin
                    if (shift_start) begin
                        remaining   <= shift_cnt;
                        modeLatched <= shift_mode;
                        busy        <= 1'b1;
                        if (shift_cnt != '0) begin
                            state    <= SEQ_SHIFT;
                            shift_en <= 1'b1;
                        end else begin
                            state <= SEQ_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                SEQ_SHIFT: begin
                    remaining <= remaining - CW'(1);
                    if (remaining <= CW'(1)) begin
                        state    <= SEQ_DONE;
                        shift_en <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                SEQ_DONE: begin
                    state <= SEQ_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state    <= SEQ_IDLE;
                    shift_en <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        case (modeLatched)
            MODE_ZERO:   fill = 1'b0;
            MODE_ONES:   fill = 1'b1;
            MODE_ROT_MC: fill = msr[FLAG_C];
            default:     fill = shout;
        endcase
    end

    always_comb begin
        case (ci_sel)
            2'd0:    co = 1'b0;
            2'd1:    co = 1'b1;
            2'd2:    co = usr[FLAG_C];
            default: co = msr[FLAG_C];
        endcase
    end

    assign ct = condEval(cond_sel[4] ? msr : usr, cond_sel[3:0]);

endmodule
